// File: rtl/alu_op_sched.sv
// Round-robin scheduler and sequencer for the signed ALU unit blocks.
// Issues one op at a time, waits for the unit flag or a timeout, then returns a tagged response.
module alu_op_sched #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req0_fun,
  input  logic [3:0]       req1_fun,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       op_fun,
  output logic             arith_enable,
  output logic             logic_enable,
  output logic             cmp_enable,
  output logic             shift_enable,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             resp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             ptr;      // 1: req1 has priority on a tie
  logic [1:0]       grant;
  logic             accept;
  logic [1:0]       unit_q;
  logic             id_q;
  logic [CW-1:0]    cnt;
  logic             limit;
  logic             sel_flag;
  logic [WIDTH-1:0] sel_out;
  logic [3:0]       en;

  // Gated by rst so no ready line is seen while reset is held.
  always_comb begin
    grant = 2'b00;
    if (rst && state == IDLE) begin
      if (req0_valid && req1_valid) grant = ptr ? 2'b10 : 2'b01;
      else                          grant = {req1_valid, req0_valid};
    end
  end

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    sel_flag = 1'b0;
    sel_out  = '0;
    case (unit_q)
      2'b00: begin sel_flag = arith_flag; sel_out = arith_out; end
      2'b01: begin sel_flag = logic_flag; sel_out = logic_out; end
      2'b10: begin sel_flag = cmp_flag;   sel_out = cmp_out;   end
      default: begin sel_flag = shift_flag; sel_out = shift_out; end
    endcase
  end

  // Limit is reached on the WAIT cycle whose increment would hit TIMEOUT.
  assign limit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en        = 4'b0000;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        en[unit_q] = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:  if (sel_flag || limit) state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign arith_enable = en[0];
  assign logic_enable = en[1];
  assign cmp_enable   = en[2];
  assign shift_enable = en[3];
  assign resp_valid   = (state == RESP);
  assign resp_id      = id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_fun    <= '0;
      unit_q    <= '0;
      id_q      <= 1'b0;
      cnt       <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= grant[1] ? req1_a        : req0_a;
        op_b   <= grant[1] ? req1_b        : req0_b;
        op_fun <= grant[1] ? req1_fun[1:0] : req0_fun[1:0];
        unit_q <= grant[1] ? req1_fun[3:2] : req0_fun[3:2];
        id_q   <= grant[1];
        ptr    <= grant[0];
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        if (sel_flag) begin
          resp_data <= sel_out;
          resp_err  <= 1'b0;
        end else if (limit) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sched.sv
// Directed bench for alu_op_sched with simple registered unit models.
module tb_alu_op_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_fun, req1_fun;
  logic [15:0] op_a, op_b;
  logic [1:0]  op_fun;
  logic        arith_enable, logic_enable, cmp_enable, shift_enable;
  logic        arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic [15:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [15:0] resp_data;
  logic        shift_dead;
  logic [3:0]  en_v;
  int          checks = 0;
  int          errors = 0;

  alu_op_sched #(.WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_fun(req0_fun), .req1_fun(req1_fun),
    .op_a(op_a), .op_b(op_b), .op_fun(op_fun),
    .arith_enable(arith_enable), .logic_enable(logic_enable),
    .cmp_enable(cmp_enable), .shift_enable(shift_enable),
    .arith_flag(arith_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .arith_out(arith_out), .logic_out(logic_out),
    .cmp_out(cmp_out), .shift_out(shift_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  assign en_v = {shift_enable, cmp_enable, logic_enable, arith_enable};

  // Unit models: flag and result registered on the enable cycle.
  always @(posedge clk) begin
    arith_flag <= arith_enable;
    logic_flag <= logic_enable;
    cmp_flag   <= cmp_enable;
    shift_flag <= shift_enable & ~shift_dead;
    arith_out  <= (op_fun == 2'b00) ? op_a + op_b : op_a - op_b;
    case (op_fun)
      2'b00:   logic_out <= op_a & op_b;
      2'b01:   logic_out <= op_a | op_b;
      2'b10:   logic_out <= op_a ^ op_b;
      default: logic_out <= ~op_a;
    endcase
    cmp_out   <= ($signed(op_a) < $signed(op_b)) ? 16'h0001 : 16'h0000;
    shift_out <= op_a << op_b[3:0];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick; tick;
    checks++;
    if ({req0_ready, req1_ready, resp_valid, en_v} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {req0_ready, req1_ready, resp_valid, en_v});
    end
    checks++;
    if ({op_a, op_b, op_fun, resp_data, resp_id, resp_err} !== 52'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {op_a, op_b, op_fun, resp_data, resp_id, resp_err});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_logic_and;
    req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_fun = 4'b0100; req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL and_ready: got %b want 10", {req0_ready, req1_ready});
    end
    tick; req0_valid = 1'b0;
    checks++;
    if ({en_v, op_fun, op_a, op_b} !== {4'b0010, 2'b00, 16'h00FF, 16'h0F0F}) begin
      errors++; $display("FAIL and_issue: got en=%b fun=%b a=%h b=%h want en=0010 fun=00 a=00ff b=0f0f", en_v, op_fun, op_a, op_b);
    end
    tick;
    checks++;
    if ({en_v, resp_valid} !== 5'd0) begin
      errors++; $display("FAIL and_wait: got en=%b valid=%b want 0", en_v, resp_valid);
    end
    tick;
    checks++;
    if ({resp_valid, resp_data, resp_id, resp_err} !== {1'b1, 16'h000F, 1'b0, 1'b0}) begin
      errors++; $display("FAIL and_resp: got v=%b d=%h id=%b err=%b want 1 000f 0 0", resp_valid, resp_data, resp_id, resp_err);
    end
    tick;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL and_idle: got valid=%b want 0", resp_valid);
    end
  endtask

  task automatic test_units;
    logic [3:0]  tfun [4];
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [15:0] texp [4];
    logic [3:0]  ten [4];
    tfun[0] = 4'b0000; ta[0] = 16'hFFFD; tb[0] = 16'h0005; texp[0] = 16'h0002; ten[0] = 4'b0001;
    tfun[1] = 4'b0001; ta[1] = 16'h0005; tb[1] = 16'h0007; texp[1] = 16'hFFFE; ten[1] = 4'b0001;
    tfun[2] = 4'b1000; ta[2] = 16'hFFFE; tb[2] = 16'h0001; texp[2] = 16'h0001; ten[2] = 4'b0100;
    tfun[3] = 4'b1100; ta[3] = 16'h0003; tb[3] = 16'h0004; texp[3] = 16'h0030; ten[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      req0_a = ta[i]; req0_b = tb[i]; req0_fun = tfun[i]; req0_valid = 1'b1;
      tick; req0_valid = 1'b0;
      checks++;
      if ({en_v, op_fun} !== {ten[i], tfun[i][1:0]}) begin
        errors++; $display("FAIL unit%0d_issue: got en=%b fun=%b want en=%b fun=%b", i, en_v, op_fun, ten[i], tfun[i][1:0]);
      end
      tick; tick;
      checks++;
      if ({resp_valid, resp_data, resp_err} !== {1'b1, texp[i], 1'b0}) begin
        errors++; $display("FAIL unit%0d_resp: got v=%b d=%h err=%b want 1 %h 0", i, resp_valid, resp_data, resp_err, texp[i]);
      end
      tick;
    end
  endtask

  task automatic test_arbitration;
    logic [3:0] gid;
    logic [3:0] rid;
    int ng, nr;
    ng = 0; nr = 0; gid = '0; rid = '0;
    rst = 1'b0; tick; rst = 1'b1;
    req0_a = 16'h0011; req0_b = 16'h0100; req0_fun = 4'b0101;
    req1_a = 16'h2000; req1_b = 16'h0002; req1_fun = 4'b0101;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (req0_ready && req1_ready) begin
        errors++; $display("FAIL arb_both_ready: cycle %0d got 11 want at most one", c);
      end
      if ((req0_ready || req1_ready) && ng < 4) begin gid[ng] = req1_ready; ng++; end
      if (resp_valid && nr < 4) begin
        rid[nr] = resp_id;
        checks++;
        if (resp_data !== (resp_id ? 16'h2002 : 16'h0111)) begin
          errors++; $display("FAIL arb_data: id=%b got %h want %h", resp_id, resp_data, resp_id ? 16'h2002 : 16'h0111);
        end
        nr++;
      end
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (ng != 4 || gid !== 4'b1010) begin
      errors++; $display("FAIL arb_grants: got n=%0d order=%b want n=4 order=1010", ng, gid);
    end
    checks++;
    if (nr != 4 || rid !== 4'b1010) begin
      errors++; $display("FAIL arb_resp_id: got n=%0d order=%b want n=4 order=1010", nr, rid);
    end
  endtask

  task automatic test_backpressure;
    resp_ready = 1'b0;
    req0_a = 16'hF0F0; req0_b = 16'hFFFF; req0_fun = 4'b0100; req0_valid = 1'b1;
    req1_a = 16'h1234; req1_b = 16'h00FF; req1_fun = 4'b0100; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_grant: got %b want 10", {req0_ready, req1_ready});
    end
    tick; req0_valid = 1'b0;
    tick; tick;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, resp_data, resp_id, req0_ready, req1_ready} !== {1'b1, 16'hF0F0, 1'b0, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h id=%b rdy=%b%b want 1 f0f0 0 00", i, resp_valid, resp_data, resp_id, req0_ready, req1_ready);
      end
      tick;
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if ({resp_valid, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_release: got v=%b rdy1=%b want 1 0", resp_valid, req1_ready);
    end
    tick;
    checks++;
    if ({resp_valid, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_next_accept: got v=%b rdy1=%b want 0 1", resp_valid, req1_ready);
    end
    tick; req1_valid = 1'b0;
    tick; tick;
    checks++;
    if ({resp_valid, resp_data, resp_id, resp_err} !== {1'b1, 16'h0034, 1'b1, 1'b0}) begin
      errors++; $display("FAIL bp_second: got v=%b d=%h id=%b err=%b want 1 0034 1 0", resp_valid, resp_data, resp_id, resp_err);
    end
    tick;
  endtask

  task automatic test_timeout;
    shift_dead = 1'b1;
    req0_a = 16'h0001; req0_b = 16'h0001; req0_fun = 4'b1100; req0_valid = 1'b1;
    tick; req0_valid = 1'b0;
    checks++;
    if (en_v !== 4'b1000) begin
      errors++; $display("FAIL to_issue: got en=%b want 1000", en_v);
    end
    for (int k = 2; k <= 5; k++) begin
      tick;
      checks++;
      if ({resp_valid, en_v} !== 5'd0) begin
        errors++; $display("FAIL to_wait_T%0d: got v=%b en=%b want 0", k, resp_valid, en_v);
      end
    end
    tick;
    checks++;
    if ({resp_valid, resp_data, resp_id, resp_err} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL to_resp: got v=%b d=%h id=%b err=%b want 1 0000 0 1", resp_valid, resp_data, resp_id, resp_err);
    end
    tick;
    shift_dead = 1'b0;
    req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_fun = 4'b0100; req0_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL to_recover_accept: got rdy0=%b want 1", req0_ready);
    end
    tick; req0_valid = 1'b0;
    tick; tick;
    checks++;
    if ({resp_valid, resp_data, resp_err} !== {1'b1, 16'h000F, 1'b0}) begin
      errors++; $display("FAIL to_recover_resp: got v=%b d=%h err=%b want 1 000f 0", resp_valid, resp_data, resp_err);
    end
    tick;
  endtask

  task automatic test_reset_mid_op;
    shift_dead = 1'b1;
    req1_a = 16'h5555; req1_b = 16'h0001; req1_fun = 4'b1100; req1_valid = 1'b1;
    tick; req1_valid = 1'b0;
    tick; tick;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, resp_valid, en_v, op_a, op_b, op_fun, resp_data, resp_id, resp_err} !== 59'd0) begin
      errors++; $display("FAIL rst_mid_async: got %h want 0", {req0_ready, req1_ready, resp_valid, en_v, op_a, op_b, op_fun, resp_data, resp_id, resp_err});
    end
    tick; tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    shift_dead = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL rst_mid_no_resp: cycle %0d got v=1 want 0", i);
      end
      tick;
    end
    req0_a = 16'h0F00; req0_b = 16'h00F0; req0_fun = 4'b0101;
    req1_a = 16'h0001; req1_b = 16'h0002; req1_fun = 4'b0101;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_grant: got %b want 10", {req0_ready, req1_ready});
    end
    tick; req0_valid = 1'b0; req1_valid = 1'b0;
    tick; tick;
    checks++;
    if ({resp_valid, resp_data, resp_id, resp_err} !== {1'b1, 16'h0FF0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_mid_resp: got v=%b d=%h id=%b err=%b want 1 0ff0 0 0", resp_valid, resp_data, resp_id, resp_err);
    end
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; resp_ready = 1'b1; shift_dead = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_fun = '0; req1_fun = '0;
    test_reset;
    test_logic_and;
    test_units;
    test_arbitration;
    test_backpressure;
    test_timeout;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sched.md
# alu_op_sched

Request scheduler and sequencer for the signed ALU datapath. It accepts operations from two independent requesters and arbitrates between them round-robin. Each granted operation is issued to exactly one registered functional unit: arithmetic, logic, compare or shift. The scheduler waits for that unit's flag and returns the result on a valid/ready response channel tagged with the requester ID. It sits between the instruction/front-end logic and the four unit blocks, and it is the only source of their `*_enable` and shared operand inputs.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width (signed).
- `TIMEOUT`, 4, maximum WAIT cycles for a unit flag before an error response (≥1).

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  signed operands.
- `req0_fun`, `req1_fun`  in  4  operation code. [3:2] is the unit: 00 arith, 01 logic, 10 cmp, 11 shift. [1:0] is the sub-op.
- `op_a`, `op_b`  out  WIDTH  shared operands to all units.
- `op_fun`  out  2  shared sub-op (`ALU_FUN`) to all units.
- `arith_enable`, `logic_enable`, `cmp_enable`, `shift_enable`  out  1  unit enables.
- `arith_flag`, `logic_flag`, `cmp_flag`, `shift_flag`  in  1  unit result-valid flags.
- `arith_out`, `logic_out`, `cmp_out`, `shift_out`  in  WIDTH  unit results.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_data`  out  WIDTH  result.
- `resp_id`  out  1  requester that issued the op.
- `resp_err`  out  1  the unit timed out.

## Operation
FSM states are IDLE, ISSUE, WAIT and RESP.

- **IDLE**
  - If any `reqN_valid` is high, grant one requester. If both are valid, grant the one not granted last. The priority pointer resets to favour req0.
  - `reqN_ready` = (state==IDLE) & grant[N]. It is combinational on valid and is never high for both requesters.
  - On accept: latch a/b/fun/id into `op_a`/`op_b`/`op_fun` and internal registers, toggle the pointer, and go to ISSUE.
- **ISSUE**
  - Assert the enable selected by fun[3:2] for exactly one cycle. The enables are one-hot or all zero.
  - Go to WAIT and clear the timeout counter.
- **WAIT**
  - All enables are low. Sample the selected unit's flag only; other flags are ignored.
  - If the flag is high, register the selected `*_out` into `resp_data`, set `resp_err`=0, and go to RESP.
  - If the flag is low, increment the counter. When the counter reaches `TIMEOUT`, set `resp_data`=0, `resp_err`=1, and go to RESP.
  - A flag seen on the same cycle as the limit wins; the response is a normal result.
- **RESP**
  - `resp_valid`=1, with `resp_data`/`resp_id`/`resp_err` held stable until `resp_ready`=1.
  - On handshake, go to IDLE.
  - No requests are accepted while in RESP.
- **Operand hold:** `op_a`/`op_b`/`op_fun` stay constant from ISSUE until the next accept. They keep their last value in IDLE.
- **Reset (any state, including mid-operation):**
  - State becomes IDLE and the pointer favours req0.
  - All outputs go to 0: `op_*`, enables, `resp_*`, and the ready lines (no grant).
  - The in-flight op is dropped and produces no response.

## Timing
- Accept at cycle T (IDLE, ready=1), ISSUE at T+1 (enable high), WAIT at T+2, and `resp_valid` rises at T+3 when the unit flag arrives the cycle after its enable.
- Minimum occupancy is 4 cycles per op with `resp_ready` tied high. The next accept is possible at T+4.
- A timeout response has `resp_valid` at T+2+`TIMEOUT`.
- Units must register their flag on the enable cycle and deassert it when the enable is low. The scheduler never re-enables a unit while waiting.
- Counter width is clog2(`TIMEOUT`+1) bits. The counter never wraps because the limit forces an exit.

## Test plan
- **Logic AND:** req0 A=16'h00FF, B=16'h0F0F, fun=4'b0100.
  - Expect `logic_enable` for one cycle, `op_fun`=2'b00, and the other enables 0.
  - Expect `resp_data`=16'h000F, `resp_id`=0, `resp_err`=0, with `resp_valid` 3 cycles after accept.
- **Arbitration:** hold both requesters valid from reset with fun=4'b0101.
  - Grants go req0, req1, req0, req1.
  - `resp_id` alternates, and ready is never high for both requesters.
- **Backpressure:** hold `resp_ready` low 5 cycles in RESP.
  - `resp_valid`, data and id stay stable.
  - `req0_ready`/`req1_ready` stay 0.
  - Release `resp_ready`; the next accept follows one cycle later.
- **Timeout:** `TIMEOUT`=4, `shift_flag` tied 0, fun=4'b1100.
  - `resp_valid` at T+6 with `resp_err`=1 and `resp_data`=0.
  - The FSM returns to IDLE and the following logic op completes normally.
- **Reset mid-op:** assert `rst` low during WAIT.
  - All outputs are 0 immediately.
  - No response appears after release.
  - The next request is granted to req0 first and completes with correct data.
